// File: rtl/gps_gen_pkg.sv
// gps_gen_pkg: register map, CTRL bit positions, frame length and shared types for gps_gen_ctrl
package gps_gen_pkg;
  localparam logic [7:0] ADDR_CTRL     = 8'h00;
  localparam logic [7:0] ADDR_N_SAT    = 8'h01;
  localparam logic [7:0] ADDR_DOPPLER  = 8'h02;
  localparam logic [7:0] ADDR_SNR      = 8'h03;
  localparam logic [7:0] ADDR_CA_PHASE = 8'h04;
  localparam logic [7:0] ADDR_MSG_LO   = 8'h05;
  localparam logic [7:0] ADDR_MSG_HI   = 8'h06;
  localparam logic [7:0] ADDR_APPLY    = 8'h07;
  localparam logic [7:0] ADDR_STATUS   = 8'h08;
  localparam int CTRL_ENA            = 0;
  localparam int CTRL_NOISE_OFF      = 1;
  localparam int CTRL_SIGNAL_OFF     = 2;
  localparam int CTRL_USE_PRESET     = 3;
  localparam int CTRL_PRESET_SEL     = 4;
  localparam int CTRL_USE_MSG_PRESET = 6;
  localparam int SPI_FRAME_LEN    = 24;
  localparam int CA_PHASE_MAX_DEF = 16367;
  typedef struct packed {
    logic [6:0]  ctrl;
    logic [4:0]  n_sat;
    logic [7:0]  doppler;
    logic [7:0]  snr;
    logic [15:0] ca_phase;
    logic [31:0] msg;
  } regs_t;
endpackage

// File: rtl/gps_spi_rx.sv
// gps_spi_rx: SPI mode-0 frame receiver; GPS_CTRL_READBACK_EN adds the MISO shifter
module gps_spi_rx
  import gps_gen_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in_n,
  input  logic        spi_sclk_in,
  input  logic        spi_cs_n_in,
  input  logic        spi_mosi_in,
  output logic        wr_stb,
  output logic [7:0]  addr,
  output logic [15:0] data
`ifdef GPS_CTRL_READBACK_EN
  ,
  output logic        rd_stb,
  input  logic [15:0] rd_data,
  output logic        spi_miso_out
`endif
);
  logic [2:0] sclk_s;
  logic [1:0] cs_s, mosi_s;
  logic [4:0] cnt;
  logic [23:0] sh;
  logic done, rise, cs_n;
  assign rise = sclk_s[1] & ~sclk_s[2];
  assign cs_n = cs_s[1];
  always_ff @(posedge clk_in or negedge rst_in_n)
    if (!rst_in_n) begin
      sclk_s <= '0;
      cs_s   <= 2'b11;
      mosi_s <= '0;
      cnt    <= '0;
      sh     <= '0;
      done   <= 1'b0;
    end else begin
      sclk_s <= {sclk_s[1:0], spi_sclk_in};
      cs_s   <= {cs_s[0], spi_cs_n_in};
      mosi_s <= {mosi_s[0], spi_mosi_in};
      done   <= ~cs_n & rise & (cnt == 5'(SPI_FRAME_LEN - 1));
      if (cs_n)
        cnt <= '0;
      else if (rise && cnt != 5'(SPI_FRAME_LEN)) begin
        cnt <= cnt + 5'd1;
        sh  <= {sh[22:0], mosi_s[1]};
      end
    end
  assign wr_stb = done & ~sh[23];
  // mid-frame the address still sits in the low byte of the shifter
  assign addr = (cnt == 5'(SPI_FRAME_LEN)) ? sh[23:16] : sh[7:0];
  assign data = sh[15:0];
`ifdef GPS_CTRL_READBACK_EN
  logic adone, fall;
  logic [15:0] tx;
  assign fall = ~sclk_s[1] & sclk_s[2];
  assign rd_stb = adone & sh[7];
  assign spi_miso_out = tx[15];
  // the falling edge right after the 8th bit must not shift: the master has not sampled the MSB yet
  always_ff @(posedge clk_in or negedge rst_in_n)
    if (!rst_in_n) begin
      adone <= 1'b0;
      tx    <= '0;
    end else begin
      adone <= ~cs_n & rise & (cnt == 5'd7);
      tx    <= cs_n ? '0 : rd_stb ? rd_data : (fall && cnt > 5'd8) ? {tx[14:0], 1'b0} : tx;
    end
`endif
endmodule

// File: rtl/gps_gen_ctrl.sv
// gps_gen_ctrl: SPI register bank, epoch-aligned apply and nav-bit sequencer; GPS_CTRL_READBACK_EN enables MISO readback
module gps_gen_ctrl
  import gps_gen_pkg::*;
#(
  parameter int EPOCHS_PER_BIT = 20,
  parameter int MSG_LEN        = 32,
  parameter int CA_PHASE_MAX   = CA_PHASE_MAX_DEF
) (
  input  logic        clk_in,
  input  logic        rst_in_n,
  input  logic        spi_sclk_in,
  input  logic        spi_cs_n_in,
  input  logic        spi_mosi_in,
  output logic        spi_miso_out,
  input  logic        epoch_in,
  output logic        ena_out,
  output logic [4:0]  n_sat_out,
  output logic [7:0]  doppler_out,
  output logic [7:0]  snr_out,
  output logic [15:0] ca_phase_out,
  output logic [5:0]  flags_out,
  output logic        msg_out,
  output logic        apply_pending_out
);
  localparam int EW = $clog2(EPOCHS_PER_BIT + 1);
  regs_t sh, act;
  logic wr_stb, pend, apply, bit_end;
  logic [7:0] addr;
  logic [15:0] data;
  logic [4:0] bit_idx, nb;
  logic [EW-1:0] epoch_cnt;
`ifdef GPS_CTRL_READBACK_EN
  logic rd_stb;
  logic [15:0] rd_data;
  gps_spi_rx u_rx (
    .clk_in(clk_in), .rst_in_n(rst_in_n), .spi_sclk_in(spi_sclk_in), .spi_cs_n_in(spi_cs_n_in),
    .spi_mosi_in(spi_mosi_in), .wr_stb(wr_stb), .addr(addr), .data(data),
    .rd_stb(rd_stb), .rd_data(rd_data), .spi_miso_out(spi_miso_out)
  );
  always_comb begin
    rd_data = '0;
    case ({1'b0, addr[6:0]})
      ADDR_CTRL:     rd_data = {9'd0, sh.ctrl};
      ADDR_N_SAT:    rd_data = {11'd0, sh.n_sat};
      ADDR_DOPPLER:  rd_data = {8'd0, sh.doppler};
      ADDR_SNR:      rd_data = {8'd0, sh.snr};
      ADDR_CA_PHASE: rd_data = sh.ca_phase;
      ADDR_MSG_LO:   rd_data = sh.msg[15:0];
      ADDR_MSG_HI:   rd_data = sh.msg[31:16];
      ADDR_STATUS:   rd_data = {15'd0, pend};
      default:       rd_data = '0;
    endcase
  end
`else
  gps_spi_rx u_rx (
    .clk_in(clk_in), .rst_in_n(rst_in_n), .spi_sclk_in(spi_sclk_in), .spi_cs_n_in(spi_cs_n_in),
    .spi_mosi_in(spi_mosi_in), .wr_stb(wr_stb), .addr(addr), .data(data)
  );
  assign spi_miso_out = 1'b0;
`endif
  // pend is set at the end of the commit cycle, so an epoch in that cycle cannot apply
  assign apply   = pend & (~act.ctrl[CTRL_ENA] | epoch_in);
  assign bit_end = epoch_in & act.ctrl[CTRL_ENA] & (epoch_cnt == EW'(EPOCHS_PER_BIT - 1));
  assign nb      = (bit_idx == '0) ? 5'(MSG_LEN - 1) : bit_idx - 5'd1;
  always_ff @(posedge clk_in or negedge rst_in_n)
    if (!rst_in_n) begin
      sh   <= '0;
      pend <= 1'b0;
    end else begin
      pend <= apply ? 1'b0 : pend | (wr_stb && addr == ADDR_APPLY);
      if (wr_stb)
        case (addr)
          ADDR_CTRL:     sh.ctrl     <= data[6:0];
          ADDR_N_SAT:    sh.n_sat    <= data[4:0];
          ADDR_DOPPLER:  sh.doppler  <= data[7:0];
          ADDR_SNR:      sh.snr      <= data[7:0];
          ADDR_CA_PHASE: sh.ca_phase <= (data > 16'(CA_PHASE_MAX)) ? 16'(CA_PHASE_MAX) : data;
          ADDR_MSG_LO:   sh.msg[15:0]  <= data;
          ADDR_MSG_HI:   sh.msg[31:16] <= data;
          default: ;
        endcase
    end
  always_ff @(posedge clk_in or negedge rst_in_n)
    if (!rst_in_n) begin
      act       <= '0;
      bit_idx   <= '0;
      epoch_cnt <= '0;
      msg_out   <= 1'b0;
    end else if (apply) begin
      act       <= sh;
      bit_idx   <= 5'(MSG_LEN - 1);
      epoch_cnt <= '0;
      msg_out   <= sh.msg[MSG_LEN-1];
    end else if (epoch_in && act.ctrl[CTRL_ENA]) begin
      epoch_cnt <= bit_end ? '0 : epoch_cnt + EW'(1);
      if (bit_end) begin
        bit_idx <= nb;
        msg_out <= act.msg[nb];
      end
    end
  assign ena_out           = act.ctrl[CTRL_ENA];
  assign n_sat_out         = act.n_sat;
  assign doppler_out       = act.doppler;
  assign snr_out           = act.snr;
  assign ca_phase_out      = act.ca_phase;
  assign flags_out         = {act.ctrl[CTRL_USE_MSG_PRESET], act.ctrl[CTRL_PRESET_SEL+:2],
                              act.ctrl[CTRL_USE_PRESET], act.ctrl[CTRL_SIGNAL_OFF], act.ctrl[CTRL_NOISE_OFF]};
  assign apply_pending_out = pend;
endmodule

// File: tb/tb_gps_gen_ctrl.sv
// tb_gps_gen_ctrl: scoreboard bench for gps_gen_ctrl; expected active registers queued at each APPLY
module tb_gps_gen_ctrl;
  typedef struct packed {
    logic        ena;
    logic [4:0]  n_sat;
    logic [7:0]  doppler;
    logic [7:0]  snr;
    logic [15:0] ca;
    logic [5:0]  flags;
    logic        msg;
  } snap_t;
  localparam int HALF = 4;
  logic clk_in = 1'b0, rst_in_n = 1'b0, sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0, epoch = 1'b0;
  logic miso, ena, msg, pend, pend_prev = 1'b0;
  logic [4:0] n_sat;
  logic [7:0] doppler, snr;
  logic [15:0] ca;
  logic [5:0] flags;
  snap_t cur, e_snap;
  snap_t exp_q[$];
  int checks = 0, errors = 0, applies = 0, pend_len = 0, last_len = 0;
  logic [6:0] m_ctrl = '0;
  logic [4:0] m_nsat = '0;
  logic [7:0] m_dop = '0, m_snr = '0;
  logic [15:0] m_ca = '0;
  logic [31:0] m_msg = '0;
  always #5 clk_in = ~clk_in;
  gps_gen_ctrl dut (
    .clk_in(clk_in), .rst_in_n(rst_in_n), .spi_sclk_in(sclk), .spi_cs_n_in(cs_n),
    .spi_mosi_in(mosi), .spi_miso_out(miso), .epoch_in(epoch), .ena_out(ena),
    .n_sat_out(n_sat), .doppler_out(doppler), .snr_out(snr), .ca_phase_out(ca),
    .flags_out(flags), .msg_out(msg), .apply_pending_out(pend)
  );
  assign cur = {ena, n_sat, doppler, snr, ca, flags, msg};
  // every falling edge of apply_pending is an apply: compare against the oldest queued expectation
  always @(negedge clk_in) begin
    if (!rst_in_n) begin
      pend_prev = 1'b0;
      pend_len  = 0;
    end else begin
      if (pend) pend_len++;
      else if (pend_prev) begin
        applies++;
        last_len = pend_len;
        pend_len = 0;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL apply_unexpected: got %h want no apply", cur);
        end else begin
          e_snap = exp_q.pop_front();
          if (cur !== e_snap) begin
            errors++;
            $display("FAIL apply_%0d: got %h want %h", applies, cur, e_snap);
          end
        end
      end
      pend_prev = pend;
    end
  end
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask
  task automatic spi_xfer(input logic [7:0] a, input logic [15:0] d, input int nbits, input bit hold,
                          output logic [23:0] rx);
    logic [23:0] f;
    f = {a, d};
    rx = '0;
    cs_n = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < nbits; i++) begin
      mosi = f[23-i];
      wait_clk(HALF);
      rx = {rx[22:0], miso};
      sclk = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
    end
    wait_clk(HALF);
    if (!hold) begin
      cs_n = 1'b1;
      wait_clk(HALF);
    end
  endtask
  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    logic [23:0] rx;
    snap_t s;
    case (a)
      8'h00: m_ctrl = d[6:0];
      8'h01: m_nsat = d[4:0];
      8'h02: m_dop = d[7:0];
      8'h03: m_snr = d[7:0];
      8'h04: m_ca = (d > 16'd16367) ? 16'd16367 : d;
      8'h05: m_msg[15:0] = d;
      8'h06: m_msg[31:16] = d;
      8'h07: begin
        s = {m_ctrl[0], m_nsat, m_dop, m_snr, m_ca, m_ctrl[6:1], m_msg[31]};
        exp_q.push_back(s);
      end
      default: ;
    endcase
    spi_xfer(a, d, 24, 1'b0, rx);
  endtask
  task automatic epoch_pulse();
    epoch = 1'b1;
    wait_clk(1);
    epoch = 1'b0;
    wait_clk(1);
  endtask
  task automatic wait_apply(input int n0, output bit ok);
    for (int t = 0; t < 300 && applies == n0; t++) @(posedge clk_in);
    #1;
    ok = (applies != n0);
  endtask
  task automatic test_reset();
    wait_clk(3);
    checks++;
    if (cur !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", cur); end
    checks++;
    if (pend !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b want 0", pend); end
    checks++;
    if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b want 0", miso); end
    rst_in_n = 1'b1;
    wait_clk(2);
  endtask
  task automatic test_apply_disabled();
    int n0;
    bit ok;
    wr(8'h01, 16'h0007);
    wr(8'h02, 16'h0040);
    n0 = applies;
    wr(8'h07, 16'h0000);
    wait_apply(n0, ok);
    checks++;
    if (!ok || last_len !== 1) begin errors++; $display("FAIL ena0_pending_len: got %0d (seen %0d) want 1", last_len, ok); end
    checks++;
    if (n_sat !== 5'd7 || doppler !== 8'h40) begin
      errors++; $display("FAIL ena0_values: got n_sat %h doppler %h want 07 40", n_sat, doppler);
    end
  endtask
  task automatic test_apply_epoch();
    int n0;
    bit ok;
    wr(8'h00, 16'h0001);
    n0 = applies;
    wr(8'h07, 16'h0000);
    wait_apply(n0, ok);
    checks++;
    if (!ok || ena !== 1'b1) begin errors++; $display("FAIL enable_apply: got ena %b (seen %0d) want 1", ena, ok); end
    wr(8'h03, 16'h0020);
    n0 = applies;
    wr(8'h07, 16'h0000);
    wait_clk(20);
    checks++;
    if (pend !== 1'b1 || snr !== 8'h00 || applies != n0) begin
      errors++; $display("FAIL wait_epoch: got pending %b snr %h want 1 00", pend, snr);
    end
    epoch_pulse();
    wait_apply(n0, ok);
    checks++;
    if (!ok || snr !== 8'h20 || pend !== 1'b0) begin
      errors++; $display("FAIL epoch_apply: got snr %h pending %b want 20 0", snr, pend);
    end
    wr(8'h03, 16'h0033);
    n0 = applies;
    epoch = 1'b1;
    wr(8'h07, 16'h0000);
    epoch = 1'b0;
    wait_apply(n0, ok);
    checks++;
    if (!ok || last_len !== 1) begin
      errors++; $display("FAIL commit_cycle_epoch: got pending len %0d (seen %0d) want 1", last_len, ok);
    end
  endtask
  task automatic test_ca_clamp();
    int n0;
    bit ok;
    wr(8'h00, 16'h007F);
    wr(8'h04, 16'hFFFF);
    n0 = applies;
    wr(8'h07, 16'h0000);
    epoch_pulse();
    wait_apply(n0, ok);
    checks++;
    if (!ok || ca !== 16'd16367 || flags !== 6'h3F) begin
      errors++; $display("FAIL ca_clamp: got ca %0d flags %h want 16367 3f", ca, flags);
    end
    wr(8'h04, 16'h0100);
    n0 = applies;
    wr(8'h07, 16'h0000);
    epoch_pulse();
    wait_apply(n0, ok);
    checks++;
    if (!ok || ca !== 16'h0100) begin errors++; $display("FAIL ca_plain: got ca %h want 0100", ca); end
  endtask
  task automatic test_nav();
    int n0;
    bit ok;
    logic b;
    wr(8'h05, 16'h0000);
    wr(8'h06, 16'hA5A5);
    n0 = applies;
    wr(8'h07, 16'h0000);
    epoch_pulse();
    wait_apply(n0, ok);
    checks++;
    if (!ok || msg !== 1'b1) begin errors++; $display("FAIL nav_start: got msg %b want 1", msg); end
    for (int k = 1; k <= 32 * 20; k++) begin
      epoch_pulse();
      b = m_msg[31 - ((k / 20) % 32)];
      checks++;
      if (msg !== b) begin errors++; $display("FAIL nav_epoch_%0d: got msg %b want %b", k, msg, b); end
    end
  endtask
  task automatic test_partial_frame();
    int n0;
    bit ok;
    logic [23:0] rx;
    spi_xfer(8'h01, 16'h001F, 13, 1'b0, rx);
    wr(8'h01, 16'h0003);
    wr(8'h10, 16'hFFFF);
    wr(8'h81, 16'h001F);
    n0 = applies;
    wr(8'h07, 16'h0000);
    epoch_pulse();
    wait_apply(n0, ok);
    checks++;
    if (!ok || n_sat !== 5'd3) begin errors++; $display("FAIL partial_frame: got n_sat %h want 03", n_sat); end
  endtask
  task automatic test_readback();
    logic [23:0] rx;
    wr(8'h02, 16'h0055);
    spi_xfer(8'h82, 16'h0000, 24, 1'b0, rx);
`ifdef GPS_CTRL_READBACK_EN
    checks++;
    if (rx[15:0] !== 16'h0055) begin errors++; $display("FAIL readback: got %h want 0055", rx[15:0]); end
`else
    checks++;
    if (rx !== 24'h0) begin errors++; $display("FAIL miso_idle: got %h want 000000", rx); end
`endif
  endtask
  task automatic test_reset_mid_frame();
    int n0;
    bit ok;
    logic [23:0] rx;
    spi_xfer(8'h03, 16'h00FF, 10, 1'b1, rx);
    rst_in_n = 1'b0;
    wait_clk(2);
    checks++;
    if (cur !== '0 || pend !== 1'b0 || miso !== 1'b0) begin
      errors++; $display("FAIL reset_mid_frame: got %h pending %b miso %b want 0", cur, pend, miso);
    end
    cs_n = 1'b1;
    m_ctrl = '0; m_nsat = '0; m_dop = '0; m_snr = '0; m_ca = '0; m_msg = '0;
    exp_q.delete();
    wait_clk(2);
    rst_in_n = 1'b1;
    wait_clk(4);
    wr(8'h01, 16'h0009);
    n0 = applies;
    wr(8'h07, 16'h0000);
    wait_apply(n0, ok);
    checks++;
    if (!ok || n_sat !== 5'd9 || ena !== 1'b0) begin
      errors++; $display("FAIL after_reset: got n_sat %h ena %b want 09 0", n_sat, ena);
    end
  endtask
  initial begin
    test_reset();
    test_apply_disabled();
    test_apply_epoch();
    test_ca_clamp();
    test_nav();
    test_partial_frame();
    test_readback();
    test_reset_mid_frame();
    wait_clk(5);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL leftover_applies: got %0d want 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
